// File: rtl/reg_fifo_pkg.sv
// Shared definitions for the register-array FIFO family: legal parameter limits
// and the ceiling-log2 helper used to size pointers and occupancy fields.
package reg_fifo_pkg;

    localparam int MinDepth = 2;
    localparam int MaxDepth = 256;
    localparam int MinWidth = 1;
    localparam int MaxWidth = 512;

    // Bits needed to encode values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        r = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                r = r + 1;
                v = v >>> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_fifo_ptr.sv
// Modulo-Depth wrapping pointer with enable and synchronous clear; wraps by
// comparison so non-power-of-2 depths cycle exactly through 0..Depth-1.
module reg_fifo_ptr
    import reg_fifo_pkg::*;
#(
    parameter int Depth = 8,
    parameter int PtrW  = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            en_i,
    output logic [PtrW-1:0] ptr_o
);

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (en_i) begin
            if (ptr_q == PtrW'(Depth - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reg_fifo_gen.sv
// Parametrised register-array synchronous FIFO with FWFT or registered read,
// synchronous flush, sticky overrun/underrun and a peak-occupancy monitor.
module reg_fifo_gen
    import reg_fifo_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32,
    parameter bit FWFT  = 1'b1,
    localparam int CW   = clog2(DEPTH + 1)
) (
    input  logic             clockCore,
    input  logic             resetCore,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] dataIn,
    input  logic             pop,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataValid,
    output logic             full,
    output logic             empty,
    input  logic [CW-1:0]    almostFullThreshold,
    input  logic [CW-1:0]    almostEmptyThreshold,
    output logic             almostFullFlag,
    output logic             almostEmptyFlag,
    output logic [CW-1:0]    fifoDepth,
    output logic [CW-1:0]    peakDepth,
    output logic             overrun,
    output logic             underrun,
    input  logic             errClear
);

    localparam int PW = clog2(DEPTH);

    if (DEPTH < MinDepth || DEPTH > MaxDepth) begin : gen_bad_depth
        $error("reg_fifo_gen: DEPTH out of range");
    end
    if (WIDTH < MinWidth || WIDTH > MaxWidth) begin : gen_bad_width
        $error("reg_fifo_gen: WIDTH out of range");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    peak_q, peak_d;
    logic             overrun_q, overrun_d;
    logic             underrun_q, underrun_d;
    logic             wr_en;
    logic             rd_en;
    logic             full_w;
    logic             empty_w;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Flush wins over both requests so nothing is written or consumed in that cycle.
    assign wr_en = push & (~full_w | pop) & ~flush;
    assign rd_en = pop & ~empty_w & ~flush;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end

        peak_d = peak_q;
        if (flush) begin
            peak_d = '0;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end

        // Sticky error bits: a new event in the same cycle as errClear stays set.
        overrun_d  = overrun_q & ~errClear;
        underrun_d = underrun_q & ~errClear;
        if (push && full_w && !pop && !flush) begin
            overrun_d = 1'b1;
        end
        if (pop && empty_w && !flush) begin
            underrun_d = 1'b1;
        end
    end

    always_ff @(posedge clockCore or negedge resetCore) begin
        if (!resetCore) begin
            count_q    <= '0;
            peak_q     <= '0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            peak_q     <= peak_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clockCore) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= dataIn;
        end
    end

    reg_fifo_ptr #(
        .Depth (DEPTH),
        .PtrW  (PW)
    ) u_wr_ptr (
        .clk_i  (clockCore),
        .rst_ni (resetCore),
        .clr_i  (flush),
        .en_i   (wr_en),
        .ptr_o  (wr_ptr)
    );

    reg_fifo_ptr #(
        .Depth (DEPTH),
        .PtrW  (PW)
    ) u_rd_ptr (
        .clk_i  (clockCore),
        .rst_ni (resetCore),
        .clr_i  (flush),
        .en_i   (rd_en),
        .ptr_o  (rd_ptr)
    );

    if (FWFT) begin : gen_fwft
        // Head word shown while non-empty; forced to zero otherwise so reset reads 0.
        assign dataValid = ~empty_w;
        assign dataOut   = empty_w ? '0 : mem_q[rd_ptr];
    end else begin : gen_reg_read
        logic [WIDTH-1:0] dout_q, dout_d;
        logic             dvalid_q, dvalid_d;

        always_comb begin
            dout_d   = dout_q;
            dvalid_d = rd_en;
            if (rd_en) begin
                dout_d = mem_q[rd_ptr];
            end
        end

        always_ff @(posedge clockCore or negedge resetCore) begin
            if (!resetCore) begin
                dout_q   <= '0;
                dvalid_q <= 1'b0;
            end else begin
                dout_q   <= dout_d;
                dvalid_q <= dvalid_d;
            end
        end

        assign dataOut   = dout_q;
        assign dataValid = dvalid_q;
    end

    assign full            = full_w;
    assign empty           = empty_w;
    assign almostFullFlag  = (count_q >= almostFullThreshold);
    assign almostEmptyFlag = (count_q <= almostEmptyThreshold);
    assign fifoDepth       = count_q;
    assign peakDepth       = peak_q;
    assign overrun         = overrun_q;
    assign underrun        = underrun_q;

endmodule

// File: tb/tb_reg_fifo_gen.sv
// Scoreboard bench: a FWFT and a registered-read FIFO (DEPTH=5, WIDTH=16) share
// stimulus and are compared every cycle against a queue-based reference model.
module tb_reg_fifo_gen;

    localparam int Depth = 5;
    localparam int Width = 16;
    localparam int Cw    = 3;

    logic             clockCore = 1'b0;
    logic             resetCore;
    logic             flush, push, pop, errClear;
    logic [Width-1:0] dataIn;
    logic [Cw-1:0]    af_thr, ae_thr;

    logic [Width-1:0] dout_f, dout_r;
    logic             dval_f, dval_r, full_f, full_r, empty_f, empty_r;
    logic             af_f, af_r, ae_f, ae_r, ov_f, ov_r, un_f, un_r;
    logic [Cw-1:0]    depth_f, depth_r, peak_f, peak_r;

    int               n_checks = 0;
    int               n_errors = 0;
    logic [Width-1:0] model_q[$];
    logic [Width-1:0] rd_exp_q[$];
    int               mpeak;
    logic             mov, mun;

    always #5 clockCore = ~clockCore;

    reg_fifo_gen #(.DEPTH(Depth), .WIDTH(Width), .FWFT(1'b1)) u_dut_fwft (
        .clockCore(clockCore), .resetCore(resetCore), .flush(flush), .push(push),
        .dataIn(dataIn), .pop(pop), .dataOut(dout_f), .dataValid(dval_f), .full(full_f),
        .empty(empty_f), .almostFullThreshold(af_thr), .almostEmptyThreshold(ae_thr),
        .almostFullFlag(af_f), .almostEmptyFlag(ae_f), .fifoDepth(depth_f),
        .peakDepth(peak_f), .overrun(ov_f), .underrun(un_f), .errClear(errClear)
    );

    reg_fifo_gen #(.DEPTH(Depth), .WIDTH(Width), .FWFT(1'b0)) u_dut_reg (
        .clockCore(clockCore), .resetCore(resetCore), .flush(flush), .push(push),
        .dataIn(dataIn), .pop(pop), .dataOut(dout_r), .dataValid(dval_r), .full(full_r),
        .empty(empty_r), .almostFullThreshold(af_thr), .almostEmptyThreshold(ae_thr),
        .almostFullFlag(af_r), .almostEmptyFlag(ae_r), .fifoDepth(depth_r),
        .peakDepth(peak_r), .overrun(ov_r), .underrun(un_r), .errClear(errClear)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        check_eq("rst_depth", 32'(depth_f), 32'(0));
        check_eq("rst_peak", 32'(peak_f), 32'(0));
        check_eq("rst_empty", 32'(empty_f), 32'(1));
        check_eq("rst_full", 32'(full_f), 32'(0));
        check_eq("rst_ov", 32'(ov_f), 32'(0));
        check_eq("rst_un", 32'(un_f), 32'(0));
        check_eq("rst_dval_f", 32'(dval_f), 32'(0));
        check_eq("rst_dout_f", 32'(dout_f), 32'(0));
        check_eq("rst_dval_r", 32'(dval_r), 32'(0));
        check_eq("rst_dout_r", 32'(dout_r), 32'(0));
        check_eq("rst_depth_r", 32'(depth_r), 32'(0));
        check_eq("rst_ae", 32'(ae_f), 32'(1));
        check_eq("rst_af", 32'(af_f), 32'(af_thr == '0));
    endtask

    task automatic check_state(input logic rd_done);
        int n;
        logic [Width-1:0] exp;
        n = model_q.size();
        check_eq("depth", 32'(depth_f), 32'(n));
        check_eq("peak", 32'(peak_f), 32'(mpeak));
        check_eq("full", 32'(full_f), 32'(n == Depth));
        check_eq("empty", 32'(empty_f), 32'(n == 0));
        check_eq("overrun", 32'(ov_f), 32'(mov));
        check_eq("underrun", 32'(un_f), 32'(mun));
        check_eq("almost_full", 32'(af_f), 32'(n >= int'(af_thr)));
        check_eq("almost_empty", 32'(ae_f), 32'(n <= int'(ae_thr)));
        check_eq("dvalid_fwft", 32'(dval_f), 32'(n != 0));
        if (n != 0) check_eq("dout_fwft", 32'(dout_f), 32'(model_q[0]));
        check_eq("depth_r", 32'(depth_r), 32'(n));
        check_eq("peak_r", 32'(peak_r), 32'(mpeak));
        check_eq("flags_r", 32'({full_r, empty_r, ov_r, un_r, af_r, ae_r}),
                 32'({full_f, empty_f, ov_f, un_f, af_f, ae_f}));
        check_eq("dvalid_reg", 32'(dval_r), 32'(rd_done));
        if (rd_done && rd_exp_q.size() > 0) begin
            exp = rd_exp_q.pop_front();
            check_eq("dout_reg", 32'(dout_r), 32'(exp));
        end
    endtask

    // Drives one cycle from just after a rising edge, updates the model, checks after the edge.
    task automatic do_cycle(input logic p, input logic [Width-1:0] d, input logic r,
                            input logic f, input logic ec);
        logic full_m, empty_m, wr_ok, rd_ok, ov_set, un_set;
        push = p; dataIn = d; pop = r; flush = f; errClear = ec;
        #1;
        if (r && !f && model_q.size() > 0) check_eq("fwft_head", 32'(dout_f), 32'(model_q[0]));
        full_m  = (model_q.size() == Depth);
        empty_m = (model_q.size() == 0);
        ov_set  = p && full_m && !r && !f;
        un_set  = r && empty_m && !f;
        rd_ok   = 1'b0;
        if (f) begin
            model_q.delete();
            mpeak = 0;
        end else begin
            wr_ok = p && (!full_m || r);
            rd_ok = r && !empty_m;
            if (rd_ok) rd_exp_q.push_back(model_q.pop_front());
            if (wr_ok) model_q.push_back(d);
            if (model_q.size() > mpeak) mpeak = model_q.size();
        end
        mov = ov_set | (mov & !ec);
        mun = un_set | (mun & !ec);
        @(posedge clockCore);
        #1;
        check_state(rd_ok);
        push = 1'b0; pop = 1'b0; flush = 1'b0; errClear = 1'b0;
    endtask

    task automatic push_w(input logic [Width-1:0] d);
        do_cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_w();
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle_w();
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        resetCore = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; errClear = 1'b0;
        dataIn = '0; af_thr = 3'd4; ae_thr = 3'd1;
        mpeak = 0; mov = 1'b0; mun = 1'b0;
        #12;
        check_reset_vals();
        resetCore = 1'b1;
        @(posedge clockCore);
        #1;

        // Fill to full and drain in order.
        for (int i = 1; i <= 5; i++) push_w(16'(i));
        for (int i = 0; i < 5; i++) pop_w();

        // Steady occupancy of 2 across two pointer wraps.
        push_w(16'h0100);
        push_w(16'h0101);
        for (int i = 0; i < 12; i++) do_cycle(1'b1, 16'(16'h0102 + i), 1'b1, 1'b0, 1'b0);
        pop_w();
        pop_w();

        // Full: push+pop keeps count, lone push overruns, clear, set-wins-over-clear.
        for (int i = 0; i < 5; i++) push_w(16'(16'h0030 + i));
        do_cycle(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        push_w(16'hBBBB);
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 16'hCCCC, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) pop_w();

        // Push+pop on empty: write accepted, underrun flagged.
        do_cycle(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Thresholds above DEPTH.
        af_thr = 3'd7;
        ae_thr = 3'd6;
        for (int i = 0; i < 5; i++) push_w(16'(16'h0700 + i));
        for (int i = 0; i < 5; i++) pop_w();
        af_thr = 3'd4;
        ae_thr = 3'd1;

        // Registered read latency.
        push_w(16'hBEEF);
        idle_w();
        pop_w();
        idle_w();

        // Flush keeps sticky flags, overrides a push, flags nothing itself.
        pop_w();
        for (int i = 0; i < 3; i++) push_w(16'(16'h0050 + i));
        do_cycle(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
        do_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        push_w(16'h0060);
        pop_w();

        // Asynchronous reset mid-fill, observed between clock edges.
        push_w(16'h0070);
        push_w(16'h0071);
        resetCore = 1'b0;
        #2;
        check_reset_vals();
        model_q.delete();
        rd_exp_q.delete();
        mpeak = 0; mov = 1'b0; mun = 1'b0;
        #1;
        resetCore = 1'b1;
        idle_w();
        push_w(16'h0080);
        pop_w();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
